encoder_layer_0_attention_output_dense_bias_sink: RTL and testbench
===================================================================

// Module: encoder_layer_0_attention_output_dense_bias_sink
// PURPOSE
//  Stream-side counterpart of the bias source: accepts a bias tensor as a valid/ready beat stream,
//  stores IN_DEPTH beats in an internal buffer, then holds it (full) until released.
//  Stored beats are read back through a registered port with the same 2-cycle latency as the parameter ROMs.
//  Used to capture streamed/updated parameters and to check source output in the layer-0 attention path.
// PARAMETERS
//  BIAS_TENSOR_SIZE_DIM_0  32  elements along dim 0
//  BIAS_TENSOR_SIZE_DIM_1  1   elements along dim 1
//  BIAS_PRECISION_0        16  element total width (bits)
//  BIAS_PRECISION_1        3   fractional bits (informational; no arithmetic on values)
//  BIAS_PARALLELISM_DIM_0  1   lanes per beat, dim 0
//  BIAS_PARALLELISM_DIM_1  1   lanes per beat, dim 1
//  IN_DEPTH  BIAS_TENSOR_SIZE_DIM_0/BIAS_PARALLELISM_DIM_0  beats per tensor
//  (derived) LANES = BIAS_PARALLELISM_DIM_0*BIAS_PARALLELISM_DIM_1; CW = $clog2(IN_DEPTH)+1
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  reset: synchronous, active-high
//  data_in        in   PREC_0 x LANES     unpacked array [LANES-1:0], lane j = element j of beat
//  data_in_valid  in   1                  beat present
//  data_in_ready  out  1                  sink can accept beat
//  full           out  1                  IN_DEPTH beats captured, buffer frozen
//  beat_count     out  CW                 beats accepted since last reset/release
//  release_buf    in   1                  1-cycle pulse: discard hold, start new capture
//  rd_en          in   1                  read enable (also pipeline enable)
//  rd_addr        in   CW                 beat index to read
//  rd_data        out  PREC_0*LANES       beat at rd_addr, lane j at [PREC_0*j +: PREC_0]
//  rd_valid       out  1                  rd_data corresponds to a read issued 2 cycles earlier
// BEHAVIOUR
//  - FSM: FILL, FULL. Reset -> FILL, beat_count=0, full=0, data_in_ready=1 (next cycle after rst low),
//    rd_valid=0, rd_data=0. Buffer contents are NOT cleared by reset.
//  - FILL: data_in_ready=1. Accept when data_in_valid&&data_in_ready: buf[beat_count] <= packed data_in,
//    beat_count++. Accept on beat_count==IN_DEPTH-1 -> FULL next cycle, beat_count=IN_DEPTH.
//  - FULL: data_in_ready=0, full=1, buffer not written. release_buf -> FILL, beat_count=0, ready=1 next cycle.
//  - release_buf in FILL: ignored (no count reset). Valid without ready: beat not taken, sender holds.
//  - data_in_ready is a registered function of state only; no combinational path from data_in_valid.
//  - Read port: stage0 <= buf[rd_addr] when rd_en; rd_data <= stage0 when rd_en; 2-cycle latency,
//    stalls (holds) when rd_en=0, like the ROM. rd_valid shifts rd_en through 2 flops (advances every cycle).
//  - rd_addr >= IN_DEPTH: rd_data = 0. Reads legal in any state; unwritten beats return stale contents.
//  - Same-cycle write and read of same index: read returns OLD contents (read-before-write).
//  - rst mid-fill: captured beats stay in buf, beat_count=0, FSM FILL; in-flight reads dropped (rd_valid=0).
// CONFIGURATION
//  BIAS_SINK_CHECKSUM_EN defined: extra port checksum out 32: wrapping 32-bit sum of every accepted lane,
//   each zero-extended from PREC_0 bits; cleared on reset and on release_buf in FULL; updated the cycle
//   after each accept; frozen in FULL.
//  Not defined: no checksum port, no adder logic.
// TESTING
//  1. Defaults, valid held high, data_in[0]=k for beat k=0..31 -> ready deasserts cycle after beat 31,
//     full=1, beat_count=32; rd_addr=5 with rd_en=1 -> rd_data=5 two cycles later, rd_valid=1.
//  2. Random valid gaps (~50%) -> exactly 32 beats stored in order, no beat lost or duplicated.
//  3. In FULL, offer 3 more beats (0xFFFF) -> ready=0, buf unchanged; release_buf -> beat_count=0, ready=1,
//     next stream of 32 beats 0x0100+k overwrites, rd_addr=31 -> 0x011F.
//  4. rst asserted after 10 beats -> beat_count=0, full=0; rd_addr=3 still returns old beat 3 value.
//  5. Same-cycle write of beat 7 (0xABCD, old 0x0007) and read addr 7 -> rd_data=0x0007; next read -> 0xABCD.
//  6. BIAS_SINK_CHECKSUM_EN, beats k=0..31 -> checksum=496; after release -> 0; rd_addr=40 -> rd_data=0.

Source files
------------

// File: rtl/encoder_layer_0_attention_output_dense_bias_sink.sv
// Bias-tensor stream sink: captures IN_DEPTH valid/ready beats, holds them until release_buf,
// and serves a 2-cycle registered read port. Optional running checksum under BIAS_SINK_CHECKSUM_EN.
module encoder_layer_0_attention_output_dense_bias_sink #(
    parameter int unsigned BIAS_TENSOR_SIZE_DIM_0 = 32,
    parameter int unsigned BIAS_TENSOR_SIZE_DIM_1 = 1,
    parameter int unsigned BIAS_PRECISION_0       = 16,
    parameter int unsigned BIAS_PRECISION_1       = 3,
    parameter int unsigned BIAS_PARALLELISM_DIM_0 = 1,
    parameter int unsigned BIAS_PARALLELISM_DIM_1 = 1,
    parameter int unsigned IN_DEPTH = BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0,
    localparam int unsigned LANES = BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1,
    localparam int unsigned CW    = $clog2(IN_DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BIAS_PRECISION_0-1:0]       data_in [LANES-1:0],
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    output logic                              full,
    output logic [CW-1:0]                     beat_count,
    input  logic                              release_buf,
    input  logic                              rd_en,
    input  logic [CW-1:0]                     rd_addr,
    output logic [BIAS_PRECISION_0*LANES-1:0] rd_data,
    output logic                              rd_valid
`ifdef BIAS_SINK_CHECKSUM_EN
    ,
    output logic [31:0]                       checksum
`endif
);

    localparam int unsigned W  = BIAS_PRECISION_0 * LANES;
    localparam int unsigned AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    if (BIAS_PRECISION_1 > BIAS_PRECISION_0 ||
        BIAS_TENSOR_SIZE_DIM_0 % BIAS_PARALLELISM_DIM_0 != 0 ||
        BIAS_TENSOR_SIZE_DIM_1 % BIAS_PARALLELISM_DIM_1 != 0) begin : g_param_check
        $error("bias sink: inconsistent tensor/precision parameters");
    end

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t         state;
    state_t         state_d;
    logic           ready_q;
    logic           accept;
    logic [W-1:0]   packed_in;
    logic [W-1:0]   mem [IN_DEPTH];
    logic [W-1:0]   stage0;
    logic           valid0;
    logic           rd_in_range;

    always_comb begin
        packed_in = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            packed_in[BIAS_PRECISION_0*j +: BIAS_PRECISION_0] = data_in[j];
        end
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            S_FILL: begin
                accept = data_in_valid && ready_q;
                if (accept && beat_count == CW'(IN_DEPTH - 1)) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (release_buf) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // ready is registered from the next state so valid never reaches it combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FILL;
            ready_q    <= 1'b0;
            beat_count <= '0;
        end else begin
            state   <= state_d;
            ready_q <= (state_d == S_FILL);
            if (accept) begin
                beat_count <= beat_count + CW'(1);
            end else if (state == S_FULL && release_buf) begin
                beat_count <= '0;
            end
        end
    end

    // Buffer contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[beat_count[AW-1:0]] <= packed_in;
        end
    end

    assign rd_in_range = (rd_addr < CW'(IN_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            stage0   <= '0;
            rd_data  <= '0;
            valid0   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            valid0   <= rd_en;
            rd_valid <= valid0;
            if (rd_en) begin
                stage0  <= rd_in_range ? mem[rd_addr[AW-1:0]] : '0;
                rd_data <= stage0;
            end
        end
    end

    assign data_in_ready = ready_q;
    assign full          = (state == S_FULL);

`ifdef BIAS_SINK_CHECKSUM_EN
    logic [31:0] lane_sum;

    always_comb begin
        lane_sum = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            lane_sum = lane_sum + 32'(data_in[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + lane_sum;
        end else if (state == S_FULL && release_buf) begin
            checksum <= '0;
        end
    end
`else
    // Checksum disabled: no port and no adder.
`endif

endmodule

// File: tb/tb_encoder_layer_0_attention_output_dense_bias_sink.sv
// Scenario-task bench for the bias sink; a read scoreboard checks every rd_valid beat
// against a bench-side model of the capture buffer.
module tb_encoder_layer_0_attention_output_dense_bias_sink;

    localparam int unsigned DEPTH = 32;
    localparam logic [5:0]  IDLE_ADDR = 6'd40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in [0:0];
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic        full;
    logic [5:0]  beat_count;
    logic        release_buf = 1'b0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_addr = IDLE_ADDR;
    logic [15:0] rd_data;
    logic        rd_valid;
`ifdef BIAS_SINK_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    encoder_layer_0_attention_output_dense_bias_sink dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .full          (full),
        .beat_count    (beat_count),
        .release_buf   (release_buf),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
`ifdef BIAS_SINK_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] val;
        bit          chk;
        logic [5:0]  addr;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] model     [DEPTH];
    bit          model_vld [DEPTH];
    int unsigned wp    = 0;
    bit          mfull = 1'b0;

    // Model of the buffer; reads are scored before the same-edge write (read-before-write)
    initial forever begin
        exp_t n;
        @(posedge clk);
        if (rst) begin
            sb.delete();
            wp    = 0;
            mfull = 1'b0;
        end else begin
            if (rd_en) begin
                n.addr = rd_addr;
                if (rd_addr >= 6'(DEPTH)) begin
                    n.val = 16'h0000;
                    n.chk = 1'b1;
                end else begin
                    n.val = model[rd_addr[4:0]];
                    n.chk = model_vld[rd_addr[4:0]];
                end
                sb.push_back(n);
            end
            if (data_in_valid && data_in_ready && !mfull) begin
                model[wp]     = data_in[0];
                model_vld[wp] = 1'b1;
                wp++;
                if (wp == DEPTH) mfull = 1'b1;
            end else if (mfull && release_buf) begin
                wp    = 0;
                mfull = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && rd_valid) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rd_scoreboard: rd_valid=1 with no read pending, required no valid");
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    tests_run++;
                    if (rd_data !== e.val) begin
                        tests_failed++;
                        $display("FAIL rd_data[%0d]: got %h required %h", e.addr, rd_data, e.val);
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] v);
        int budget = 50;
        data_in[0]    = v;
        data_in_valid = 1'b1;
        while (!data_in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!data_in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: ready=%b required 1", data_in_ready);
        end
        @(negedge clk);
    endtask

    task automatic pulse_release();
        data_in_valid = 1'b0;
        release_buf   = 1'b1;
        @(negedge clk);
        release_buf   = 1'b0;
    endtask

    task automatic read_range(input int unsigned lo, input int unsigned hi);
        for (int unsigned a = lo; a <= hi; a++) begin
            rd_addr = 6'(a);
            @(negedge clk);
        end
        rd_addr = IDLE_ADDR;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (beat_count !== 6'd0 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: count=%0d full=%b required 0/0", beat_count, full);
        end
        tests_run++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_read: rd_valid=%b rd_data=%h required 0/0000", rd_valid, rd_data);
        end
        rst   = 1'b0;
        rd_en = 1'b1;
        @(negedge clk);
        tests_run++;
        if (data_in_ready !== 1'b1 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: ready=%b full=%b required 1/0", data_in_ready, full);
        end
    endtask

    task automatic test_fill_continuous();
        for (int k = 0; k < 31; k++) send_beat(16'(k));
        tests_run++;
        if (data_in_ready !== 1'b1 || full !== 1'b0 || beat_count !== 6'd31) begin
            tests_failed++;
            $display("FAIL fill_last_minus_one: ready=%b full=%b count=%0d required 1/0/31",
                     data_in_ready, full, beat_count);
        end
        send_beat(16'd31);
        data_in_valid = 1'b0;
        tests_run++;
        if (data_in_ready !== 1'b0 || full !== 1'b1 || beat_count !== 6'd32) begin
            tests_failed++;
            $display("FAIL fill_full: ready=%b full=%b count=%0d required 0/1/32",
                     data_in_ready, full, beat_count);
        end
        rd_addr = 6'd5;
        @(negedge clk);
        rd_addr = IDLE_ADDR;
        @(negedge clk);
        tests_run++;
        if (rd_data !== 16'd5 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_addr5: data=%h valid=%b required 0005/1", rd_data, rd_valid);
        end
        read_range(0, DEPTH - 1);
    endtask

    task automatic test_read_before_write();
        pulse_release();
        for (int k = 0; k < 7; k++) send_beat(16'(k));
        data_in[0]    = 16'hABCD;
        data_in_valid = 1'b1;
        rd_addr       = 6'd7;
        @(negedge clk);
        data_in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rd_data !== 16'h0007) begin
            tests_failed++;
            $display("FAIL rbw_old: got %h required 0007", rd_data);
        end
        rd_addr = IDLE_ADDR;
        @(negedge clk);
        tests_run++;
        if (rd_data !== 16'hABCD || beat_count !== 6'd8) begin
            tests_failed++;
            $display("FAIL rbw_new: data=%h count=%0d required abcd/8", rd_data, beat_count);
        end
        for (int k = 8; k < 32; k++) send_beat(16'(k));
        data_in_valid = 1'b0;
    endtask

    task automatic test_full_hold_release();
        data_in[0]    = 16'hFFFF;
        data_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (data_in_ready !== 1'b0 || beat_count !== 6'd32 || full !== 1'b1) begin
                tests_failed++;
                $display("FAIL full_hold[%0d]: ready=%b count=%0d full=%b required 0/32/1",
                         i, data_in_ready, beat_count, full);
            end
        end
        data_in_valid = 1'b0;
        read_range(0, DEPTH - 1);
        pulse_release();
        tests_run++;
        if (beat_count !== 6'd0 || data_in_ready !== 1'b1 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL release: count=%0d ready=%b full=%b required 0/1/0",
                     beat_count, data_in_ready, full);
        end
        for (int k = 0; k < 32; k++) send_beat(16'h0100 + 16'(k));
        data_in_valid = 1'b0;
        rd_addr = 6'd31;
        @(negedge clk);
        rd_addr = IDLE_ADDR;
        @(negedge clk);
        tests_run++;
        if (rd_data !== 16'h011F || full !== 1'b1) begin
            tests_failed++;
            $display("FAIL overwrite_31: data=%h full=%b required 011f/1", rd_data, full);
        end
    endtask

    task automatic test_random_gaps();
        pulse_release();
        for (int k = 0; k < 32; k++) begin
            if (k == 16) begin
                pulse_release();
                tests_run++;
                if (beat_count !== 6'd16) begin
                    tests_failed++;
                    $display("FAIL release_in_fill: count=%0d required 16", beat_count);
                end
            end
            send_beat(16'h2000 + 16'(k));
            if ($urandom_range(1, 0) == 1) begin
                data_in_valid = 1'b0;
                data_in[0]    = 16'hDEAD;
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
        end
        data_in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (beat_count !== 6'd32 || full !== 1'b1 || wp != DEPTH) begin
            tests_failed++;
            $display("FAIL gaps_count: count=%0d full=%b accepted=%0d required 32/1/32",
                     beat_count, full, wp);
        end
        read_range(0, DEPTH - 1);
    endtask

    task automatic test_rst_mid_fill();
        pulse_release();
        for (int k = 0; k < 10; k++) send_beat(16'h3000 + 16'(k));
        data_in_valid = 1'b0;
        rd_addr = 6'd2;
        rst     = 1'b1;
        @(negedge clk);
        rd_addr = IDLE_ADDR;
        @(negedge clk);
        tests_run++;
        if (beat_count !== 6'd0 || full !== 1'b0 || rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_fill: count=%0d full=%b rd_valid=%b required 0/0/0",
                     beat_count, full, rd_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (data_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_ready: ready=%b required 1", data_in_ready);
        end
        rd_addr = 6'd3;
        @(negedge clk);
        rd_addr = IDLE_ADDR;
        @(negedge clk);
        tests_run++;
        if (rd_data !== 16'h3003) begin
            tests_failed++;
            $display("FAIL rst_keeps_buf: got %h required 3003", rd_data);
        end
    endtask

    task automatic test_checksum_oob();
        for (int k = 0; k < 32; k++) send_beat(16'(k));
        data_in[0] = 16'hFFFF;
        repeat (2) @(negedge clk);
        data_in_valid = 1'b0;
        tests_run++;
        if (full !== 1'b1 || beat_count !== 6'd32) begin
            tests_failed++;
            $display("FAIL refill: full=%b count=%0d required 1/32", full, beat_count);
        end
`ifdef BIAS_SINK_CHECKSUM_EN
        tests_run++;
        if (checksum !== 32'd496) begin
            tests_failed++;
            $display("FAIL checksum_full: got %0d required 496", checksum);
        end
`endif
        pulse_release();
`ifdef BIAS_SINK_CHECKSUM_EN
        tests_run++;
        if (checksum !== 32'd0) begin
            tests_failed++;
            $display("FAIL checksum_release: got %0d required 0", checksum);
        end
`endif
        rd_addr = 6'd10;
        @(negedge clk);
        rd_addr = IDLE_ADDR;
        @(negedge clk);
        tests_run++;
        if (rd_data !== 16'd10) begin
            tests_failed++;
            $display("FAIL read_addr10: got %h required 000a", rd_data);
        end
        @(negedge clk);
        tests_run++;
        if (rd_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL read_oob40: got %h required 0000", rd_data);
        end
    endtask

    initial begin
        data_in[0] = 16'h0000;
        test_reset();
        test_fill_continuous();
        test_read_before_write();
        test_full_hold_release();
        test_random_gaps();
        test_rst_mid_fill();
        test_checksum_oob();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
